// File: rtl/id_seq_pkg.sv
// Shared types, limits and the BCD substitution rule used by the ID digit sequencer.
package id_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         MAX_DIGITS = 8;

    // Non-BCD codes are replaced by zero before they reach the consumer.
    function automatic logic [3:0] bcd_sanitize(input logic [3:0] digit);
        return (digit > BCD_MAX) ? 4'd0 : digit;
    endfunction

endpackage

// File: rtl/bcd_parity_gen.sv
// Combinational BCD sanitizer and parity generator for one stored digit.
module bcd_parity_gen
    import id_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] bcd,
    output logic       odd_par,
    output logic       even_par,
    output logic       invalid
);

    logic [3:0] w_bcd;

    assign w_bcd    = bcd_sanitize(digit);
    assign bcd      = w_bcd;
    assign invalid  = (digit > BCD_MAX);
    // Parity always covers the substituted value, never the raw code.
    assign even_par = ^w_bcd;
    assign odd_par  = ~(^w_bcd);

endmodule

// File: rtl/id_sequence_controller.sv
// Holds a programmable ID digit string and streams it one BCD digit per
// valid/ready handshake, with start/abort/done sequencing and a sticky BCD error.
module id_sequence_controller
    import id_seq_pkg::*;
#(
    parameter int NUM_DIGITS = 7,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_addr,
    input  logic [3:0]       load_digit,
    input  logic             start,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_digit,
    output logic             out_odd_par,
    output logic             out_even_par,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err_bcd
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [3:0]       r_mem [NUM_DIGITS];
    logic             r_err_bcd;

    logic             w_load_we;
    logic             w_start_ok;
    logic [3:0]       w_rd_digit;
    logic [3:0]       w_bcd;
    logic             w_odd_par;
    logic             w_even_par;
    logic             w_invalid;

    // Abort also blocks loads so an aborting cycle never alters storage.
    assign w_load_we  = (r_state == IDLE) && load_en && !abort;
    assign w_start_ok = (r_state == IDLE) && start && !abort;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_mem[gi] <= 4'd0;
                end else if (w_load_we && (load_addr == IDX_W'(gi))) begin
                    r_mem[gi] <= load_digit;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        if (abort) begin
            w_state_next = IDLE;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_next = EMIT;
                        w_idx_next   = '0;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (r_idx == LAST_IDX) begin
                            w_state_next = DONE;
                            w_idx_next   = '0;
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                    end
                end
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // idx is parked at 0 outside EMIT, so the read port shows slot 0 when idle.
    assign w_rd_digit = r_mem[r_idx];

    bcd_parity_gen u_bcd_parity_gen (
        .digit    (w_rd_digit),
        .bcd      (w_bcd),
        .odd_par  (w_odd_par),
        .even_par (w_even_par),
        .invalid  (w_invalid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_bcd <= 1'b0;
        end else if (w_start_ok) begin
            r_err_bcd <= 1'b0;
        end else if (out_valid && w_invalid) begin
            r_err_bcd <= 1'b1;
        end
    end

    assign out_valid    = (r_state == EMIT);
    assign busy         = (r_state == EMIT);
    assign done         = (r_state == DONE);
    assign out_last     = (r_state == EMIT) && (r_idx == LAST_IDX);
    assign out_digit    = w_bcd;
    assign out_odd_par  = w_odd_par;
    assign out_even_par = w_even_par;
    // The flag rises in the same cycle the bad digit is first presented.
    assign err_bcd      = r_err_bcd | (out_valid & w_invalid);

endmodule
